// File: rtl/lshift_sat.sv
// lshift_sat: two-stage elastic left-shift rescaler with per-element saturation.
// Define LSHIFT_SAT_SATURATE_EN to clamp overflowing elements; otherwise data wraps.

module lshift_sat_elem #(
    parameter int W     = 16,
    parameter int SHIFT = 4
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         ovf
);
    localparam int FW = W + SHIFT;

    logic [FW-1:0] full;
    logic [SHIFT:0] hi;

    assign full = FW'($signed(x)) << SHIFT;
    // The product fits only if every bit above the result's sign bit matches it.
    assign hi   = full[FW-1:W-1];
    assign ovf  = !((&hi) || (~|hi));

`ifdef LSHIFT_SAT_SATURATE_EN
    assign y = !ovf        ? full[W-1:0] :
               full[FW-1]  ? {1'b1, {(W-1){1'b0}}} :
                             {1'b0, {(W-1){1'b1}}};
`else
    assign y = full[W-1:0];
`endif
endmodule

module lshift_sat #(
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 4,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 2,
    parameter int TOTAL_INPUT_W = 2,
    parameter int SHIFT         = 4,
    localparam int ELEMENTS_PER_VEC = CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES,
    localparam int VECTOR_BITS      = WIDTH_OUT * ELEMENTS_PER_VEC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VECTOR_BITS-1:0] in_vec [TOTAL_INPUT_W],
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VECTOR_BITS-1:0] out_vec [TOTAL_INPUT_W],
    output logic                   out_sat,
    input  logic                   sat_clr,
    output logic [15:0]            sat_count
);
    localparam int STAGES = 2;
    localparam int NEL    = TOTAL_INPUT_W * ELEMENTS_PER_VEC;

    logic [STAGES:1]        vld_pipe;
    logic [VECTOR_BITS-1:0] s1_data [TOTAL_INPUT_W];
    logic [VECTOR_BITS-1:0] res     [TOTAL_INPUT_W];
    logic [NEL-1:0]         ovf_flat;
    logic                   res_sat;
    logic                   adv2;
    logic                   acc;

    genvar w, e;
    generate
        for (w = 0; w < TOTAL_INPUT_W; w++) begin : g_vec
            for (e = 0; e < ELEMENTS_PER_VEC; e++) begin : g_el
                lshift_sat_elem #(.W(WIDTH_OUT), .SHIFT(SHIFT)) u_elem (
                    .x   (s1_data[w][VECTOR_BITS-1-e*WIDTH_OUT -: WIDTH_OUT]),
                    .y   (res[w][VECTOR_BITS-1-e*WIDTH_OUT -: WIDTH_OUT]),
                    .ovf (ovf_flat[w*ELEMENTS_PER_VEC+e])
                );
            end
        end
    endgenerate

    assign res_sat   = |ovf_flat;
    assign out_valid = vld_pipe[2];
    assign adv2      = vld_pipe[1] && (!vld_pipe[2] || out_ready);
    assign in_ready  = !vld_pipe[1] || adv2;
    assign acc       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            out_sat   <= 1'b0;
            sat_count <= '0;
            for (int i = 0; i < TOTAL_INPUT_W; i++) begin
                s1_data[i] <= '0;
                out_vec[i] <= '0;
            end
        end else begin
            // S1 is free to load whenever it is empty or draining this cycle.
            if (in_ready) vld_pipe[1] <= acc;
            if (acc) s1_data <= in_vec;

            if (adv2) begin
                vld_pipe[2] <= 1'b1;
                out_vec     <= res;
                out_sat     <= res_sat;
            end else if (out_ready) begin
                vld_pipe[2] <= 1'b0;
            end

            if (sat_clr)
                sat_count <= '0;
            else if (vld_pipe[2] && out_ready && out_sat && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_lshift_sat.sv
// Directed bench for lshift_sat: hand-computed vectors plus a scoreboard for streams.

module tb_lshift_sat;
    localparam int W = 16, EPV = 32, VB = 512, TIW = 2, SH = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, out_sat, sat_clr;
    logic [VB-1:0] in_vec  [TIW];
    logic [VB-1:0] out_vec [TIW];
    logic [15:0]   sat_count;

    int errs = 0, checks = 0, cyc = 0, nrx = 0, nacc = 0, rs_err = 0;

    typedef struct { logic [VB-1:0] i0; logic [VB-1:0] i1; } beat_t;
    beat_t sb[$];
    int    hs_cyc[$];

    lshift_sat dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [VB-1:0] got, input logic [VB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mel(input logic [15:0] x);
        int p;
        logic [31:0] pv;
        p  = int'($signed(x)) * (1 << SH);
        pv = p;
`ifdef LSHIFT_SAT_SATURATE_EN
        if (p > 32767)  return {1'b1, 16'h7FFF};
        if (p < -32768) return {1'b1, 16'h8000};
`else
        if (p > 32767 || p < -32768) return {1'b1, pv[15:0]};
`endif
        return {1'b0, pv[15:0]};
    endfunction

    function automatic logic [VB:0] mvec(input logic [VB-1:0] v);
        logic [VB-1:0] r;
        logic          s;
        logic [16:0]   m;
        r = '0;
        s = 1'b0;
        for (int e = 0; e < EPV; e++) begin
            m = mel(v[VB-1-e*W -: W]);
            r[VB-1-e*W -: W] = m[15:0];
            s = s | m[16];
        end
        return {s, r};
    endfunction

    function automatic logic [VB-1:0] fill(input logic [15:0] x);
        return {EPV{x}};
    endfunction

    function automatic logic [VB-1:0] rvec();
        logic [VB-1:0] v;
        logic [15:0]   x;
        for (int e = 0; e < EPV; e++) begin
            x = 16'($urandom);
            if ($urandom_range(0, 1) == 1) x = {{4{x[11]}}, x[11:0]};
            v[VB-1-e*W -: W] = x;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rcheck(input logic [VB-1:0] iv, input logic [VB-1:0] ov);
        logic [16:0] m;
        logic signed [15:0] oe, ie;
        for (int e = 0; e < EPV; e++) begin
            ie = iv[VB-1-e*W -: W];
            oe = ov[VB-1-e*W -: W];
            m  = mel(ie);
            if (!m[16] && ((oe >>> SH) != ie)) rs_err++;
        end
    endtask

    // One clock with scoreboard bookkeeping for the handshakes about to happen.
    task automatic cycle();
        beat_t       b;
        logic [VB:0] e0, e1;
        #1;
        if (in_valid && in_ready) begin
            sb.push_back('{in_vec[0], in_vec[1]});
            nacc++;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", VB'(1), VB'(0));
            end else begin
                b  = sb.pop_front();
                e0 = mvec(b.i0);
                e1 = mvec(b.i1);
                chk("sb_vec0", out_vec[0], e0[VB-1:0]);
                chk("sb_vec1", out_vec[1], e1[VB-1:0]);
                chk("sb_sat", VB'(out_sat), VB'(e0[VB] | e1[VB]));
                rcheck(b.i0, out_vec[0]);
                rcheck(b.i1, out_vec[1]);
            end
            hs_cyc.push_back(cyc);
            nrx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 12 && sb.size() > 0; k++) cycle();
        chk("drain_empty", VB'(sb.size()), VB'(0));
    endtask

    task automatic single(input string tag, input logic [VB-1:0] v0, input logic [VB-1:0] v1,
                          input logic [VB-1:0] x0, input logic [VB-1:0] x1, input logic xs);
        in_valid  = 1'b1;
        in_vec[0] = v0;
        in_vec[1] = v1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, VB'(out_valid), VB'(0));
        step();
        chk({tag, "_valid"}, VB'(out_valid), VB'(1));
        chk({tag, "_vec0"}, out_vec[0], x0);
        chk({tag, "_vec1"}, out_vec[1], x1);
        chk({tag, "_sat"}, VB'(out_sat), VB'(xs));
        step();
    endtask

    logic [VB-1:0] mix, mix_exp, snap;
    int            rx0, acc0, seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        in_vec[0] = '0; in_vec[1] = '0;
        repeat (3) step();
        chk("rst_out_valid", VB'(out_valid), VB'(0));
        chk("rst_out_sat", VB'(out_sat), VB'(0));
        chk("rst_sat_count", VB'(sat_count), VB'(0));
        chk("rst_out_vec", out_vec[0], '0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", VB'(in_ready), VB'(1));

        single("basic", fill(16'h0123), fill(16'h0123), fill(16'h1230), fill(16'h1230), 1'b0);
        single("f800", fill(16'hF800), fill(16'hF800), fill(16'h8000), fill(16'h8000), 1'b0);
        single("ffff", fill(16'hFFFF), fill(16'hFFFF), fill(16'hFFF0), fill(16'hFFF0), 1'b0);
        single("07ff", fill(16'h07FF), fill(16'h07FF), fill(16'h7FF0), fill(16'h7FF0), 1'b0);
        mix = fill(16'h0001);
        mix[15:0] = 16'h0800;
        mix_exp = fill(16'h0010);
`ifdef LSHIFT_SAT_SATURATE_EN
        single("0800", fill(16'h0800), fill(16'h0800), fill(16'h7FFF), fill(16'h7FFF), 1'b1);
        single("f7ff", fill(16'hF7FF), fill(16'hF7FF), fill(16'h8000), fill(16'h8000), 1'b1);
        single("8000", fill(16'h8000), fill(16'h8000), fill(16'h8000), fill(16'h8000), 1'b1);
        mix_exp[15:0] = 16'h7FFF;
`else
        single("0800", fill(16'h0800), fill(16'h0800), fill(16'h8000), fill(16'h8000), 1'b1);
        single("f7ff", fill(16'hF7FF), fill(16'hF7FF), fill(16'h7FF0), fill(16'h7FF0), 1'b1);
        single("8000", fill(16'h8000), fill(16'h8000), fill(16'h0000), fill(16'h0000), 1'b1);
        mix_exp[15:0] = 16'h8000;
`endif
        single("mixed", fill(16'h0001), mix, fill(16'h0010), mix_exp, 1'b1);
        chk("directed_sat_count", VB'(sat_count), VB'(4));

        // Back-to-back random stream.
        rx0 = nrx; rs_err = 0; hs_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_vec[0] = rvec(); in_vec[1] = rvec();
            cycle();
        end
        drain();
        chk("stream_count", VB'(nrx - rx0), VB'(10));
        if (hs_cyc.size() > 0) chk("stream_consecutive", VB'(hs_cyc[$] - hs_cyc[0]), VB'(9));
        chk("stream_rshift", VB'(rs_err), VB'(0));

        // Backpressure: five stalled cycles while offering beats.
        out_ready = 1'b0; rx0 = nrx; acc0 = nacc;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_vec[0] = rvec(); in_vec[1] = rvec();
            cycle();
            if (i == 1) snap = out_vec[0];
        end
        #1;
        chk("bp_accepted", VB'(nacc - acc0), VB'(2));
        chk("bp_in_ready", VB'(in_ready), VB'(0));
        chk("bp_out_stable", out_vec[0], snap);
        chk("bp_no_output", VB'(nrx - rx0), VB'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (nacc - acc0) < 6; k++) begin
            in_valid = 1'b1; in_vec[0] = rvec(); in_vec[1] = rvec();
            cycle();
        end
        drain();
        chk("bp_received", VB'(nrx - rx0), VB'(6));

        // sat_count: three saturating handshakes, then clear racing a fourth.
        sat_clr = 1'b1; cycle(); sat_clr = 1'b0;
        chk("clr_sat_count", VB'(sat_count), VB'(0));
        in_vec[0] = fill(16'h0800); in_vec[1] = fill(16'h0800);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; cycle();
        end
        drain();
        chk("sat_count_3", VB'(sat_count), VB'(3));
        out_ready = 1'b0; in_valid = 1'b1; cycle(); in_valid = 1'b0; cycle(); cycle();
        chk("sat4_held", VB'(out_valid & out_sat), VB'(1));
        chk("sat4_pre_count", VB'(sat_count), VB'(3));
        out_ready = 1'b1; sat_clr = 1'b1; cycle(); sat_clr = 1'b0;
        chk("sat_clr_priority", VB'(sat_count), VB'(0));
        chk("sat4_drained", VB'(out_valid), VB'(0));

        // Reset with both stages full.
        in_valid = 1'b1; cycle(); drain();
        chk("pre_rst_count", VB'(sat_count), VB'(1));
        out_ready = 1'b0; in_valid = 1'b1;
        in_vec[0] = fill(16'h0055); in_vec[1] = fill(16'h0055);
        cycle(); cycle();
        in_valid = 1'b0;
        chk("full_in_ready", VB'(in_ready), VB'(0));
        chk("full_out_valid", VB'(out_valid), VB'(1));
        rst = 1'b1; step(); rst = 1'b0; sb.delete();
        chk("mid_rst_out_valid", VB'(out_valid), VB'(0));
        chk("mid_rst_sat_count", VB'(sat_count), VB'(0));
        chk("mid_rst_out_vec", out_vec[1], '0);
        out_ready = 1'b1; seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (out_valid) seen++;
        end
        chk("mid_rst_no_ghost", VB'(seen), VB'(0));
        chk("mid_rst_in_ready", VB'(in_ready), VB'(1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
